// File: rtl/pbs_pkg.sv
// Shared constants, FSM state encoding and move table for the pbs_turn_engine slice.
package pbs_pkg;

    localparam int ACC_W  = 4;
    localparam int LFSR_W = 16;

    // Tap mask for x^16+x^14+x^13+x^11+1 (state bits 15, 13, 12, 10).
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ROLL,
        ST_CALC,
        ST_APPLY,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [3:0]       dmg;
        logic [ACC_W-1:0] acc;
    } move_t;

    function automatic move_t move_lookup(input logic [2:0] idx);
        move_t m;
        case (idx)
            3'd0:    m = '{dmg: 4'd1,  acc: 4'd15};
            3'd1:    m = '{dmg: 4'd3,  acc: 4'd12};
            3'd2:    m = '{dmg: 4'd5,  acc: 4'd8};
            3'd3:    m = '{dmg: 4'd8,  acc: 4'd4};
            3'd4:    m = '{dmg: 4'd2,  acc: 4'd14};
            3'd5:    m = '{dmg: 4'd4,  acc: 4'd10};
            3'd6:    m = '{dmg: 4'd6,  acc: 4'd6};
            default: m = '{dmg: 4'd15, acc: 4'd1};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pbs_lfsr.sv
// 16-bit Fibonacci LFSR, shifts left with feedback into bit 0; a zero seed falls back to 16'hACE1.
module pbs_lfsr
    import pbs_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] INIT = (SEED == '0) ? LFSR_DEFAULT_SEED : SEED;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= INIT;
        end else begin
            state <= {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/pbs_turn_engine.sv
// Resolves one attack turn between two of N fighters behind a start/done handshake.
// Optional critical hits are enabled by defining PBS_CRIT_EN (adds the crit output).
module pbs_turn_engine
    import pbs_pkg::*;
#(
    parameter int          N_FIGHTERS = 2,
    parameter int          HP_W       = 4,
    parameter int          MOVE_W     = 2,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(N_FIGHTERS)-1:0]  attacker,
    input  logic [$clog2(N_FIGHTERS)-1:0]  target,
    input  logic                           ai_turn,
    input  logic [MOVE_W-1:0]              p_move,
    output logic                           busy,
    output logic                           done,
    output logic                           hit,
    output logic [MOVE_W-1:0]              last_move,
    output logic [N_FIGHTERS*HP_W-1:0]     hp,
    output logic [N_FIGHTERS-1:0]          fainted,
`ifdef PBS_CRIT_EN
    output logic                           crit,
`endif
    output logic [2:0]                     dbg_state,
    output logic                           game_over
);

    localparam int IDX_W = $clog2(N_FIGHTERS);
    // Damage path is wide enough to hold a doubled 15 before clipping to max HP.
    localparam int DW = (HP_W > 5) ? HP_W + 1 : 6;
    localparam logic [HP_W-1:0] HP_MAX   = '1;
    localparam logic [DW-1:0]   HP_MAX_D = DW'(HP_MAX);

    state_t              state;
    logic [IDX_W-1:0]    att_q, tgt_q;
    logic                ai_q;
    logic [MOVE_W-1:0]   pmove_q, move_q;
    logic [DW-1:0]       dmg_q;
    logic [ACC_W-1:0]    acc_q;
    logic                hit_q;
    logic [HP_W-1:0]     new_hp_q;
    logic [HP_W-1:0]     hp_r [N_FIGHTERS];
    logic [LFSR_W-1:0]   lfsr;
    logic                lfsr_unused;

    pbs_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    logic              att_ok, tgt_ok, hit_now;
    logic [HP_W-1:0]   att_hp, tgt_hp;
    logic [MOVE_W-1:0] sel_move;
    move_t             sel_entry;
    logic [DW-1:0]     dmg_clip;

    assign lfsr_unused = ^lfsr;
    assign att_ok      = 32'(att_q) < N_FIGHTERS;
    assign tgt_ok      = 32'(tgt_q) < N_FIGHTERS;
    assign att_hp      = att_ok ? hp_r[att_q] : '0;
    assign tgt_hp      = tgt_ok ? hp_r[tgt_q] : '0;
    assign sel_move    = ai_q ? lfsr[MOVE_W-1:0] : pmove_q;
    assign sel_entry   = move_lookup(3'(sel_move));
    // Out-of-range or fainted participants read as HP 0, which forces a miss.
    assign hit_now     = (acc_q >= lfsr[15:12]) && (att_hp != '0) && (tgt_hp != '0);
    assign dmg_clip    = (dmg_q > HP_MAX_D) ? HP_MAX_D : dmg_q;

`ifdef PBS_CRIT_EN
    logic          crit_q, crit_now;
    logic [DW-1:0] dmg_dbl;
    assign crit_now = hit_now && (lfsr[7:6] == 2'b11);
    assign dmg_dbl  = {dmg_q[DW-2:0], 1'b0};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit       <= 1'b0;
            last_move <= '0;
            att_q     <= '0;
            tgt_q     <= '0;
            ai_q      <= 1'b0;
            pmove_q   <= '0;
            move_q    <= '0;
            dmg_q     <= '0;
            acc_q     <= '0;
            hit_q     <= 1'b0;
            new_hp_q  <= '0;
`ifdef PBS_CRIT_EN
            crit_q    <= 1'b0;
            crit      <= 1'b0;
`endif
            for (int i = 0; i < N_FIGHTERS; i++) hp_r[i] <= HP_MAX;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        att_q   <= attacker;
                        tgt_q   <= target;
                        ai_q    <= ai_turn;
                        pmove_q <= p_move;
                        busy    <= 1'b1;
                        state   <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    move_q <= sel_move;
                    dmg_q  <= DW'(sel_entry.dmg);
                    acc_q  <= sel_entry.acc;
                    state  <= ST_ROLL;
                end
                ST_ROLL: begin
                    hit_q <= hit_now;
`ifdef PBS_CRIT_EN
                    crit_q <= crit_now;
                    if (crit_now) dmg_q <= (dmg_dbl > HP_MAX_D) ? HP_MAX_D : dmg_dbl;
`endif
                    state <= ST_CALC;
                end
                ST_CALC: begin
                    if (hit_q && (DW'(tgt_hp) > dmg_clip)) new_hp_q <= tgt_hp - dmg_clip[HP_W-1:0];
                    else if (hit_q)                         new_hp_q <= '0;
                    else                                    new_hp_q <= tgt_hp;
                    state <= ST_APPLY;
                end
                ST_APPLY: begin
                    if (tgt_ok) hp_r[tgt_q] <= new_hp_q;
                    done      <= 1'b1;
                    hit       <= hit_q;
                    last_move <= move_q;
`ifdef PBS_CRIT_EN
                    crit      <= crit_q;
`endif
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

    for (genvar i = 0; i < N_FIGHTERS; i++) begin : g_hp
        assign hp[i*HP_W +: HP_W] = hp_r[i];
        assign fainted[i]         = (hp_r[i] == '0);
    end

    always_comb begin
        int alive;
        alive = 0;
        for (int i = 0; i < N_FIGHTERS; i++) begin
            if (!fainted[i]) alive++;
        end
        game_over = (alive <= 1);
    end

endmodule

// File: tb/tb_pbs_turn_engine.sv
// Scoreboard bench for pbs_turn_engine: a behavioural turn model pushes expected results, a monitor checks each done pulse.
module tb_pbs_turn_engine;
    import pbs_pkg::*;

    localparam int          N      = 2;
    localparam int          HP_W   = 4;
    localparam int          MOVE_W = 2;
    localparam int          HP_MAX = 15;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [0:0]          attacker = '0;
    logic [0:0]          target = '0;
    logic                ai_turn = 1'b0;
    logic [MOVE_W-1:0]   p_move = '0;
    logic                busy, done, hit, game_over;
    logic [MOVE_W-1:0]   last_move;
    logic [N*HP_W-1:0]   hp;
    logic [N-1:0]        fainted;
    logic [2:0]          dbg_state;
`ifdef PBS_CRIT_EN
    logic                crit;
`endif

    pbs_turn_engine #(.N_FIGHTERS(N), .HP_W(HP_W), .MOVE_W(MOVE_W), .SEED(SEED)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .attacker  (attacker),
        .target    (target),
        .ai_turn   (ai_turn),
        .p_move    (p_move),
        .busy      (busy),
        .done      (done),
        .hit       (hit),
        .last_move (last_move),
        .hp        (hp),
        .fainted   (fainted),
`ifdef PBS_CRIT_EN
        .crit      (crit),
`endif
        .dbg_state (dbg_state),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              hit;
        logic [MOVE_W-1:0] move;
        logic [N*HP_W-1:0] hp;
        logic [N-1:0]      fainted;
        logic              game_over;
        logic              crit;
        int                cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [15:0] lfsr_m = SEED;
    int          hp_m[N];
    int          dmg_tab[8] = '{1, 3, 5, 8, 2, 4, 6, 15};
    int          acc_tab[8] = '{15, 12, 8, 4, 14, 10, 6, 1};

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference generator tracking the DUT's free-running sequence cycle by cycle.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        lfsr_m <= !rst ? SEED : lfsr_next(lfsr_m);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    function automatic bit model_game_over();
        int alive = 0;
        for (int i = 0; i < N; i++) if (hp_m[i] > 0) alive++;
        return alive <= 1;
    endfunction

    // Turn outcome from the rules: v is the generator value in the cycle where start is sampled.
    function automatic exp_t predict(input logic [15:0] v, input int att, input int tgt,
                                     input bit ai, input int pm);
        exp_t        e;
        logic [15:0] l1, l2;
        int          mv, dmg, acc, alive;
        int          nh[N];
        l1    = lfsr_next(v);
        l2    = lfsr_next(l1);
        mv    = ai ? int'(l1[MOVE_W-1:0]) : pm;
        dmg   = dmg_tab[mv];
        acc   = acc_tab[mv];
        e.hit = (acc >= int'(l2[15:12])) && att < N && tgt < N && hp_m[att] > 0 && hp_m[tgt] > 0;
        e.crit = 1'b0;
`ifdef PBS_CRIT_EN
        if (e.hit && l2[7:6] == 2'b11) begin
            e.crit = 1'b1;
            dmg    = (2 * dmg > HP_MAX) ? HP_MAX : 2 * dmg;
        end
`endif
        if (dmg > HP_MAX) dmg = HP_MAX;
        nh = hp_m;
        if (e.hit) nh[tgt] = (nh[tgt] > dmg) ? nh[tgt] - dmg : 0;
        alive = 0;
        for (int i = 0; i < N; i++) begin
            e.hp[i*HP_W +: HP_W] = HP_W'(nh[i]);
            e.fainted[i]         = (nh[i] == 0);
            if (nh[i] != 0) alive++;
        end
        e.game_over = (alive <= 1);
        e.move      = MOVE_W'(mv);
        e.cyc       = 0;
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) flag("wait_idle");
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            flag("done_timeout");
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // want_crit: -1 any, 0 must not crit, 1 must crit. Idles until the model predicts a qualifying turn.
    task automatic issue(input int att, input int tgt, input bit ai, input int pm,
                         input bit need_hit, input int want_crit, input bit hold);
        exp_t e;
        int   tries = 0;
        wait_idle();
        e = predict(lfsr_m, att, tgt, ai, pm);
        while ((need_hit && !e.hit) || (want_crit >= 0 && int'(e.crit) != want_crit)) begin
            if (tries == 400) break;
            start = 1'b0;
            @(negedge clk);
            tries++;
            e = predict(lfsr_m, att, tgt, ai, pm);
        end
        if (tries == 400) begin
            flag("turn_search");
            start = 1'b0;
            return;
        end
        e.cyc = cyc + 5;
        exp_q.push_back(e);
        for (int i = 0; i < N; i++) hp_m[i] = int'(e.hp[i*HP_W +: HP_W]);
        attacker = 1'(att);
        target   = 1'(tgt);
        ai_turn  = ai;
        p_move   = MOVE_W'(pm);
        start    = 1'b1;
        @(negedge clk);
        if (!hold || model_game_over()) start = 1'b0;
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) hp_m[i] = HP_MAX;
    endtask

    always @(negedge clk) begin
        if (rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: done=1 with no turn outstanding (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("busy_in_done", busy, 1'b1);
                check("hit", hit, mon_e.hit);
                check("last_move", last_move, mon_e.move);
                check("hp", hp, mon_e.hp);
                check("fainted", fainted, mon_e.fainted);
                check("game_over", game_over, mon_e.game_over);
`ifdef PBS_CRIT_EN
                check("crit", crit, mon_e.crit);
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) hp_m[i] = HP_MAX;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hit", hit, 1'b0);
        check("rst_last_move", last_move, '0);
        check("rst_hp", hp, 8'hFF);
        check("rst_fainted", fainted, 2'b00);
        check("rst_game_over", game_over, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);

        issue(0, 1, 1'b0, 0, 1'b0, 0, 1'b0);
        wait_drain();
        check("first_turn_hp", hp, 8'hEF);
        check("first_turn_hit", hit, 1'b1);

        repeat (12) issue(0, 1, 1'b0, 0, 1'b0, 0, 1'b0);
        wait_drain();
        check("hp1_at_2", hp, 8'h2F);

        issue(0, 1, 1'b0, 3, 1'b1, 0, 1'b0);
        wait_drain();
        check("ko_hp", hp, 8'h0F);
        check("ko_fainted", fainted, 2'b10);
        check("ko_game_over", game_over, 1'b1);

        issue(0, 1, 1'b0, 0, 1'b0, -1, 1'b0);
        wait_drain();
        check("fainted_target_hit", hit, 1'b0);
        check("fainted_target_hp", hp, 8'h0F);

        do_reset();
        for (int i = 0; i < 50; i++) begin
            if (model_game_over()) begin
                wait_drain();
                do_reset();
            end
            issue($urandom_range(0, 1), $urandom_range(0, 1), 1'b1, $urandom_range(0, 3),
                  1'b0, -1, ($urandom_range(0, 3) == 0) && (i < 49));
        end
        wait_drain();

        do_reset();
        issue(0, 1, 1'b0, 0, 1'b0, 0, 1'b0);
        wait_drain();
        check("pre_abort_hp", hp, 8'hEF);
        wait_idle();
        attacker = 1'b0;
        target   = 1'b1;
        ai_turn  = 1'b0;
        p_move   = '0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_calc", dbg_state, ST_CALC);
        rst = 1'b0;
        @(negedge clk);
        check("abort_hp", hp, 8'hFF);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_state", dbg_state, ST_IDLE);
        rst = 1'b1;
        for (int i = 0; i < N; i++) hp_m[i] = HP_MAX;
        repeat (10) @(negedge clk);

`ifdef PBS_CRIT_EN
        do_reset();
        issue(0, 1, 1'b0, 1, 1'b1, 1, 1'b0);
        wait_drain();
        check("crit_hp", hp, 8'h9F);
        check("crit_flag", crit, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pbs_turn_engine.md
# pbs_turn_engine

Parametrised successor to the two-fighter battle datapath. Resolves one complete attack turn between any two of N fighters: move selection (player or AI), accuracy roll, saturating damage and HP write-back. Sequencing is handled by an internal FSM behind a start/done handshake, so the top-level controller only issues one `start` per turn. A deterministic, seedable LFSR replaces free-running ring-oscillator RNGs, so turns are reproducible in simulation.

## Interface
- `N_FIGHTERS`, default 2: number of combatants, 2..8.
- `HP_W`, default 4: HP width. Max HP is 2^HP_W−1.
- `MOVE_W`, default 2: move index width, 1..3.
- `SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'hACE1.
- `clk` input 1: clock. Everything is rising-edge.
- `rst` input 1: reset, synchronous, active-low.
- `start` input 1: begin a turn. Sampled only in IDLE.
- `attacker` input $clog2(N_FIGHTERS): attacking fighter index.
- `target` input $clog2(N_FIGHTERS): defending fighter index. May equal `attacker` (self-hit).
- `ai_turn` input 1: 0 = use `p_move`; 1 = move drawn from the LFSR.
- `p_move` input MOVE_W: player-chosen move.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at end of turn.
- `hit` output 1: result of the last turn. Held until the next `done`.
- `last_move` output MOVE_W: move used in the last turn. Held.
- `hp` output N_FIGHTERS*HP_W: flat HP bus. Fighter i occupies bits [i*HP_W +: HP_W].
- `fainted` output N_FIGHTERS: bit i is set iff HP of fighter i is 0.
- `game_over` output 1: high when at most one fighter is not fainted.

## Operation
- FSM states: IDLE → SELECT → ROLL → CALC → APPLY → DONE → IDLE.
- IDLE → SELECT on `start`. `attacker`, `target`, `ai_turn` and `p_move` are latched on that edge.
- SELECT: move = `ai_turn` ? lfsr[MOVE_W-1:0] : latched `p_move`. Table lookup gives dmg and acc.
- ROLL: roll = lfsr[15:12], 4 bits. `hit` = (acc ≥ roll).
  - If the attacker is fainted, force `hit`=0.
  - If the target is already fainted, force `hit`=0.
- CALC: new_hp = hit ? (cur_hp > dmg ? cur_hp − dmg : 0) : cur_hp.
  - The subtraction saturates at 0 and never wraps.
  - dmg is clipped to max HP before the compare.
- APPLY: write new_hp to the target. `fainted` and `game_over` are combinational from `hp`.
- DONE: `done`=1 for this state only; `hit` and `last_move` update.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts left with feedback into bit 0. Advances every cycle, including IDLE.
- Reset:
  - All HP = max HP; FSM returns to IDLE; LFSR = SEED.
  - `busy`, `done`, `hit` = 0; `last_move` = 0.
  - Reset mid-turn aborts the turn with no HP write.
- `start` is ignored while `busy`=1. `start` held high starts a new turn on the first IDLE cycle.
- Out-of-range `attacker`/`target` (≥ N_FIGHTERS): the turn completes with `hit`=0 and no write.

## Timing
- Latency: `start` sampled at edge 0; HP written at edge 4; `done` high during the cycle after edge 4.
- A turn takes exactly 5 cycles, IDLE to IDLE. Back-to-back `start` gives one turn every 6 cycles.
- `hp` changes only at the APPLY edge.

## Configuration
- `PBS_CRIT_EN` defined:
  - In ROLL, crit = (lfsr[7:6] == 2'b11).
  - On a crit hit, dmg is doubled (saturating at max HP) before CALC.
  - Extra output `crit`, 1 bit, is held with `hit`.
- `PBS_CRIT_EN` undefined: no crit logic and no `crit` port.

## Structure
- Package `pbs_pkg` holds:
  - 8-entry move table, index: dmg/acc.
    - 0: 1/15
    - 1: 3/12
    - 2: 5/8
    - 3: 8/4
    - 4: 2/14
    - 5: 4/10
    - 6: 6/6
    - 7: 15/1
  - FSM state enum.
  - Constants ACC_W=4 and LFSR_W=16.
  - LFSR tap constant.
- Sub-module `pbs_lfsr` (seed parameter, sync active-low reset), exposing `state[15:0]`.

## Test plan
- Reset, then `start` with attacker 0, target 1, `p_move`=0 → `done` 5 cycles later; `hit`=1; hp[1]=14; hp[0]=15.
- Drive hp[1] to 2 via move-0 turns, then apply move 3 on a turn where the model predicts a hit → hp[1]=0 (no wrap), `fainted`[1]=1, `game_over`=1.
- With target 1 fainted, issue a move-0 turn → `hit`=0, hp unchanged, `done` still pulses after 5 cycles.
- `ai_turn`=1 with SEED default → `last_move` and `hit` match the LFSR reference model over 50 turns.
- Assert `rst` low during CALC → next cycle all hp=15, `busy`=0, no `done` pulse.
- With `PBS_CRIT_EN` defined, move 1 on a model-predicted crit hit against hp=15 → hp=9, `crit`=1.
